// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - hz_state_t   : controller FSM encoding (RUN / MEM_WAIT / FAULT)
//   - STALL_CNT_W  : width of the consecutive memory-stall counter
//   - PERF_CNT_W   : width of the performance counters
//   - detect_loaduse() : load-use hazard detection helper
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hz_state_t;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned PERF_CNT_W  = 32;

    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = {PERF_CNT_W{1'b1}};
    localparam logic [PERF_CNT_W-1:0] PERF_CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

    // A load in EX whose destination feeds the instruction in ID cannot be
    // covered by forwarding. x0 is never a real dependency.
    function automatic logic detect_loaduse(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        detect_loaduse = memread && (rd != 5'd0) &&
                         ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// -----------------------------------------------------------------------------
// hazard_perf_counter
// Saturating event counter; holds at all-ones instead of wrapping.
// Ports:
//   in_clk    : clock, rising edge
//   in_rst_n  : asynchronous active-low reset (count -> 0)
//   in_en     : count one event this cycle
//   out_count : current count
// -----------------------------------------------------------------------------
module hazard_perf_counter
    import hazard_pkg::*;
(
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_en,
    output logic [PERF_CNT_W-1:0] out_count
);

    logic [PERF_CNT_W-1:0] r_count_r;

    // Event counter register, saturating at its maximum value.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_count_r <= {PERF_CNT_W{1'b0}};
        end else if (in_en && (r_count_r != PERF_CNT_MAX)) begin
            r_count_r <= r_count_r + PERF_CNT_ONE;
        end else begin
            r_count_r <= r_count_r;
        end
    end

    assign out_count = r_count_r;

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Hazard and stall sequencer for the 5-stage RISC-V pipeline. Drives the
// write enables of PC, IF/ID, ID/EX, EX/MEM and the flush controls of IF/ID,
// ID/EX and MEM/WB. Handles, in priority order: watchdog fault, data-memory
// stall, taken branch, load-use hazard.
//
// Parameter:
//   MEM_TIMEOUT : consecutive memory-stall cycles tolerated before the sticky
//                 fault (1..65535)
// Ports:
//   in_clk, in_rst_n              : clock / async active-low reset
//   in_idex_memread, in_idex_rd   : load in EX and its destination
//   in_ifid_rs1/rs2, in_ifid_uses_rs2 : sources of the instruction in ID
//   in_branch_taken               : branch/jump resolved taken in EX
//   in_dmem_req, in_dmem_ready    : data-memory handshake of MEM stage
//   out_*_write                   : stage register enables (combinational)
//   out_*_flush                   : bubble insertion (combinational)
//   out_mem_fault                 : sticky watchdog fault
//   out_stall_cycles, out_flush_count : performance counters
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> saturating stall-cycle and branch-flush counters
//   undefined -> both counter outputs tied to zero, no counter flops
// -----------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_idex_memread,
    input  logic [4:0]            in_idex_rd,
    input  logic [4:0]            in_ifid_rs1,
    input  logic [4:0]            in_ifid_rs2,
    input  logic                  in_ifid_uses_rs2,
    input  logic                  in_branch_taken,
    input  logic                  in_dmem_req,
    input  logic                  in_dmem_ready,
    output logic                  out_pc_write,
    output logic                  out_ifid_write,
    output logic                  out_idex_write,
    output logic                  out_exmem_write,
    output logic                  out_ifid_flush,
    output logic                  out_idex_flush,
    output logic                  out_memwb_flush,
    output logic                  out_mem_fault,
    output logic [PERF_CNT_W-1:0] out_stall_cycles,
    output logic [PERF_CNT_W-1:0] out_flush_count
);

    // One extra bit so the incremented count can never wrap before compare.
    localparam logic [STALL_CNT_W:0] TIMEOUT_LIMIT = MEM_TIMEOUT[STALL_CNT_W:0];
    localparam logic [STALL_CNT_W:0] CNT_ONE       = {{STALL_CNT_W{1'b0}}, 1'b1};

    hz_state_t              r_state_r;
    hz_state_t              w_state_next_s;
    logic [STALL_CNT_W-1:0] r_stall_cnt_r;
    logic [STALL_CNT_W-1:0] w_stall_cnt_next_s;
    logic [STALL_CNT_W:0]   w_cnt_inc_s;
    logic                   w_memstall_s;
    logic                   w_loaduse_s;
    logic                   w_branch_flush_s;

    assign w_memstall_s = in_dmem_req && !in_dmem_ready;
    assign w_loaduse_s  = detect_loaduse(in_idex_memread, in_idex_rd, in_ifid_rs1,
                                         in_ifid_rs2, in_ifid_uses_rs2);

    // FSM state and consecutive-stall counter registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state_r     <= RUN;
            r_stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            r_state_r     <= w_state_next_s;
            r_stall_cnt_r <= w_stall_cnt_next_s;
        end
    end

    // Next-state logic; the stall count is the number of this cycle within the
    // current run of stalled cycles (RUN always starts a fresh run at 1).
    always_comb begin
        w_state_next_s     = r_state_r;
        w_stall_cnt_next_s = r_stall_cnt_r;
        if (r_state_r == MEM_WAIT) begin
            w_cnt_inc_s = {1'b0, r_stall_cnt_r} + CNT_ONE;
        end else begin
            w_cnt_inc_s = CNT_ONE;
        end
        case (r_state_r)
            RUN, MEM_WAIT: begin
                if (w_memstall_s && (w_cnt_inc_s >= TIMEOUT_LIMIT)) begin
                    w_state_next_s     = FAULT;
                    w_stall_cnt_next_s = {STALL_CNT_W{1'b0}};
                end else if (w_memstall_s) begin
                    w_state_next_s     = MEM_WAIT;
                    w_stall_cnt_next_s = w_cnt_inc_s[STALL_CNT_W-1:0];
                end else begin
                    w_state_next_s     = RUN;
                    w_stall_cnt_next_s = {STALL_CNT_W{1'b0}};
                end
            end
            FAULT: begin
                w_state_next_s     = FAULT;
                w_stall_cnt_next_s = {STALL_CNT_W{1'b0}};
            end
            default: begin
                w_state_next_s     = RUN;
                w_stall_cnt_next_s = {STALL_CNT_W{1'b0}};
            end
        endcase
    end

    // Pipeline control outputs. Reset forces the default (free-running)
    // controls at once, even while the inputs still describe a stall.
    always_comb begin
        out_pc_write     = 1'b1;
        out_ifid_write   = 1'b1;
        out_idex_write   = 1'b1;
        out_exmem_write  = 1'b1;
        out_ifid_flush   = 1'b0;
        out_idex_flush   = 1'b0;
        out_memwb_flush  = 1'b0;
        out_mem_fault    = 1'b0;
        w_branch_flush_s = 1'b0;
        if (!in_rst_n) begin
            w_branch_flush_s = 1'b0;
        end else begin
            case (r_state_r)
                FAULT: begin
                    out_pc_write    = 1'b0;
                    out_ifid_write  = 1'b0;
                    out_idex_write  = 1'b0;
                    out_exmem_write = 1'b0;
                    out_memwb_flush = 1'b1;
                    out_mem_fault   = 1'b1;
                end
                RUN, MEM_WAIT: begin
                    if (w_memstall_s) begin
                        // Freeze everything; the branch stays in EX and
                        // re-presents itself once memory completes.
                        out_pc_write    = 1'b0;
                        out_ifid_write  = 1'b0;
                        out_idex_write  = 1'b0;
                        out_exmem_write = 1'b0;
                        out_memwb_flush = 1'b1;
                    end else if (in_branch_taken) begin
                        // Wrong-path ID instruction is squashed, so any
                        // load-use dependency it had no longer matters.
                        w_branch_flush_s = 1'b1;
                    end else if (w_loaduse_s) begin
                        out_pc_write   = 1'b0;
                        out_ifid_write = 1'b0;
                        out_idex_flush = 1'b1;
                    end else begin
                        w_branch_flush_s = 1'b0;
                    end
                end
                default: begin
                    w_branch_flush_s = 1'b0;
                end
            endcase
            if (w_branch_flush_s) begin
                out_ifid_flush = 1'b1;
                out_idex_flush = 1'b1;
            end else begin
                out_ifid_flush = out_ifid_flush;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter u_stall_cnt (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_en     (!out_pc_write),
        .out_count (out_stall_cycles)
    );

    hazard_perf_counter u_flush_cnt (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_en     (w_branch_flush_s),
        .out_count (out_flush_count)
    );
`else
    assign out_stall_cycles = {PERF_CNT_W{1'b0}};
    assign out_flush_count  = {PERF_CNT_W{1'b0}};
`endif

endmodule
